mem_loader: RTL and testbench
=============================

# mem_loader

Host-side loader that drives the processor top level's external memory-access ports. It accepts a byte-serial command stream (valid/ready) from a host link and turns each command into the port activity the top level arbitrates: instruction-memory writes, data-memory writes, and reads of either memory. Read results go back to the host as a byte stream, and the loader can issue the start pulse that launches the processor. It sits between the host interface (UART/JTAG bridge) and the top level.

## Interface
- `READ_LAT`, 3: cycles `read_en_ext` is held before the read word is sampled (covers top-level address register plus memory output register).
- `WR_HOLD`, 2: cycles write strobe, address and data are held stable.
- `clk` in 1: system clock, all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_data` in 8, `rx_valid` in 1, `rx_ready` out 1: command byte stream; a byte transfers when `rx_valid && rx_ready` at a rising edge.
- `tx_data` out 8, `tx_valid` out 1, `tx_ready` in 1: response byte stream; same transfer rule.
- `addr_ext` out 16: memory address to the top level.
- `iram_in_ext` out 16: instruction write word.
- `data_in_ext` out 16: data write word.
- `mem_write_ins` out 1: instruction-memory write strobe.
- `mem_write_data_ext` out 1: data-memory write strobe.
- `read_en_ext` out 2: bit0 = instruction read, bit1 = data read.
- `iram_in` in 16, `dram_in` in 16: memory read data.
- `start` out 1: processor start pulse.
- `busy` out 1: high in any state other than IDLE.
- `err` out 1: one-cycle pulse on an illegal opcode.

## Operation
- Command framing: opcode byte, then payload; multi-byte fields are MSB first.
  - 0x01 WRI: addr_hi, addr_lo, data_hi, data_lo; writes instruction memory.
  - 0x02 WRD: same payload; writes data memory.
  - 0x03 RDI: addr_hi, addr_lo; reads instruction memory.
  - 0x04 RDD: addr_hi, addr_lo; reads data memory.
  - 0x05 GO: no payload; issues `start`.
- States and transitions:
  - IDLE → ADDR_HI on a legal opcode. GO instead goes to START.
  - ADDR_HI → ADDR_LO.
  - ADDR_LO → DATA_HI for writes, READ for reads.
  - DATA_HI → DATA_LO → WRITE.
  - WRITE → IDLE after `WR_HOLD` cycles.
  - READ → TX_HI after `READ_LAT` cycles. TX_HI → TX_LO → IDLE.
  - START → IDLE.
- `rx_ready` is high only in IDLE, ADDR_HI, ADDR_LO, DATA_HI and DATA_LO.
- WRITE:
  - `addr_ext` and the selected data word are driven.
  - The selected strobe is high for exactly `WR_HOLD` consecutive cycles.
  - Only one strobe is ever high.
- READ:
  - `read_en_ext` has exactly one bit set for `READ_LAT` cycles, with `addr_ext` stable.
  - On the last READ cycle, `iram_in` or `dram_in` is latched into a 16-bit response register and `read_en_ext` returns to 0.
- TX_HI / TX_LO:
  - `tx_valid` is high and `tx_data` is the response high byte, then the low byte.
  - Each state is held until `tx_ready`. `tx_data` must not change while `tx_valid && !tx_ready`.
- Illegal opcode: byte consumed, `err` pulses for 1 cycle, state stays IDLE, no memory activity.
- `start` is high for exactly one cycle in START.
- Write and read enables are never asserted together. The loader never drives a write while the processor runs; the host serialises commands.

## Timing
- Reset (asynchronous, immediate): every output goes to 0, including `rx_ready`, `tx_valid`, the strobes, `read_en_ext`, `addr_ext`, both data words, `start`, `busy` and `err`. State goes to IDLE.
- `rx_ready` rises on the first rising edge after `rst_n` deasserts.
- Reset mid-command (any state) abandons the command. Strobes and `read_en_ext` drop asynchronously. No partial response is sent.
- All outputs are registered; nothing combinational from inputs to outputs.
- Write latency: the strobe rises on the edge after the data_lo byte is accepted.
- Read latency: `tx_valid` rises `READ_LAT`+1 edges after the addr_lo byte is accepted (with `tx_ready` high).
- Back-to-back commands: the next opcode is accepted on the first IDLE cycle. There are no dead cycles beyond the state sequence.
- `rx_valid` may drop between bytes; the FSM waits in its current state.

## Configuration
- `LOADER_AUTOINC_EN` defined:
  - A 16-bit address pointer is loaded by every addressed command and increments by 1 (wrapping 0xFFFF→0x0000) after each completed WRI/WRD/RDI/RDD.
  - Opcodes with bit7 set (0x81–0x84) skip the address bytes and use the pointer.
- `LOADER_AUTOINC_EN` undefined:
  - There is no pointer.
  - 0x81–0x84 are illegal opcodes (`err` pulse).

## Test plan
- Write then read instruction memory:
  - Stimulus: bytes 01 00 05 12 34.
  - Required: `mem_write_ins` high 2 cycles with `addr_ext`=0x0005 and `iram_in_ext`=0x1234.
  - Then bytes 03 00 05 with the memory model returning 0x1234 → tx bytes 12, 34.
- Data write:
  - Stimulus: bytes 02 01 00 BE EF.
  - Required: `mem_write_data_ext` high 2 cycles with `addr_ext`=0x0100 and `data_in_ext`=0xBEEF; `mem_write_ins` stays 0.
- Backpressure:
  - Stimulus: RDD at 0x0003 with the model returning 0xA55A; hold `tx_ready`=0 for 10 cycles.
  - Required: `tx_valid`=1 and `tx_data`=0xA5 stable throughout, then 0x5A after release.
- Illegal opcode and GO:
  - Stimulus: byte 0x7F → required: `err` 1-cycle pulse, no strobes.
  - Stimulus: byte 05 → required: `start` high exactly 1 cycle, `busy` back to 0 next cycle.
- Reset mid-write:
  - Stimulus: assert `rst_n`=0 during the first WRITE cycle of WRI 00 09 FF FF.
  - Required: strobe drops immediately, all outputs 0.
  - After release, RDI 00 09 returns the pre-existing memory content.
- Auto-increment (with `LOADER_AUTOINC_EN`):
  - Stimulus: 01 00 FF 00 01, then 81 00 02.
  - Required: the second write targets 0x0100.
  - Stimulus: pointer at 0xFFFF after WRI to 0xFFFE → required: pointer wraps to 0x0000.

Source files
------------

// File: rtl/mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : mem_loader
// Purpose  : Host-side loader for the processor top level. Decodes a
//            byte-serial command stream into instruction/data memory writes,
//            memory reads (returned as two response bytes) and a start pulse.
// Ports    : clk, rst_n                   - clock, async active-low reset
//            rx_data/rx_valid/rx_ready    - command byte stream in
//            tx_data/tx_valid/tx_ready    - response byte stream out
//            addr_ext, iram_in_ext,
//            data_in_ext                  - memory address / write words
//            mem_write_ins,
//            mem_write_data_ext           - write strobes
//            read_en_ext                  - bit0 instr read, bit1 data read
//            iram_in, dram_in             - memory read data
//            start, busy, err             - start pulse, activity, bad opcode
// Options  : LOADER_AUTOINC_EN - auto-incrementing address pointer and the
//            address-less opcodes 0x81..0x84.
// Revision : 1.0 - initial release
// ============================================================================
module mem_loader #(
  parameter int READ_LAT = 3,
  parameter int WR_HOLD  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [15:0] addr_ext,
  output logic [15:0] iram_in_ext,
  output logic [15:0] data_in_ext,
  output logic        mem_write_ins,
  output logic        mem_write_data_ext,
  output logic [1:0]  read_en_ext,
  input  logic [15:0] iram_in,
  input  logic [15:0] dram_in,
  output logic        start,
  output logic        busy,
  output logic        err
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_ADDR_HI = 4'd1,
    S_ADDR_LO = 4'd2,
    S_DATA_HI = 4'd3,
    S_DATA_LO = 4'd4,
    S_WRITE   = 4'd5,
    S_READ    = 4'd6,
    S_TX_HI   = 4'd7,
    S_TX_LO   = 4'd8,
    S_START   = 4'd9
  } state_t;

  localparam logic [7:0] c_wr_last = 8'(WR_HOLD - 1);
  localparam logic [7:0] c_rd_last = 8'(READ_LAT - 1);

  state_t      r_state;
  state_t      w_next;

  logic        r_is_write;
  logic        r_is_data;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata_hi;
  logic [7:0]  r_resp_lo;
  logic [7:0]  r_cnt;

  logic        r_rx_ready;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;
  logic [15:0] r_addr_ext;
  logic [15:0] r_iram_in_ext;
  logic [15:0] r_data_in_ext;
  logic        r_wr_ins;
  logic        r_wr_data;
  logic [1:0]  r_read_en;
  logic        r_start;
  logic        r_busy;
  logic        r_err;

`ifdef LOADER_AUTOINC_EN
  logic [15:0] r_ptr;
`endif

  logic        w_rx_fire;
  logic        w_op_legal;
  logic        w_op_go;
  logic        w_op_auto;
  logic        w_op_write;
  logic        w_op_data;
  logic        w_sel_data;
  logic [15:0] w_addr_word;
  logic [15:0] w_rd_word;
  logic        w_enter_write;
  logic        w_enter_read;

  assign w_rx_fire = rx_valid && r_rx_ready;

  // Opcode decode; only meaningful while the FSM sits in IDLE.
  always_comb begin
    w_op_legal = 1'b0;
    w_op_go    = 1'b0;
    w_op_auto  = 1'b0;
    w_op_write = 1'b0;
    w_op_data  = 1'b0;
    case (rx_data)
      8'h01: begin w_op_legal = 1'b1; w_op_write = 1'b1; end
      8'h02: begin w_op_legal = 1'b1; w_op_write = 1'b1; w_op_data = 1'b1; end
      8'h03: begin w_op_legal = 1'b1; end
      8'h04: begin w_op_legal = 1'b1; w_op_data = 1'b1; end
      8'h05: begin w_op_go = 1'b1; end
`ifdef LOADER_AUTOINC_EN
      8'h81: begin w_op_legal = 1'b1; w_op_auto = 1'b1; w_op_write = 1'b1; end
      8'h82: begin w_op_legal = 1'b1; w_op_auto = 1'b1; w_op_write = 1'b1; w_op_data = 1'b1; end
      8'h83: begin w_op_legal = 1'b1; w_op_auto = 1'b1; end
      8'h84: begin w_op_legal = 1'b1; w_op_auto = 1'b1; w_op_data = 1'b1; end
`endif
      default: ;
    endcase
  end

  // Pointer-addressed reads go straight from IDLE to READ, before r_is_data
  // has been loaded, so the memory select must come from the decoder there.
  assign w_sel_data = (r_state == S_IDLE) ? w_op_data : r_is_data;

  // Full address of the command in flight, including the byte being
  // accepted this cycle when it completes the address.
  always_comb begin
    w_addr_word = r_addr;
    if (r_state == S_ADDR_LO) begin
      w_addr_word = {r_addr[15:8], rx_data};
    end
`ifdef LOADER_AUTOINC_EN
    if (r_state == S_IDLE) begin
      w_addr_word = r_ptr;
    end
`endif
  end

  assign w_rd_word = r_is_data ? dram_in : iram_in;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_rx_fire) begin
          if (w_op_go) begin
            w_next = S_START;
          end else if (w_op_legal) begin
            if (w_op_auto) begin
              w_next = w_op_write ? S_DATA_HI : S_READ;
            end else begin
              w_next = S_ADDR_HI;
            end
          end
        end
      end
      S_ADDR_HI: if (w_rx_fire) w_next = S_ADDR_LO;
      S_ADDR_LO: if (w_rx_fire) w_next = r_is_write ? S_DATA_HI : S_READ;
      S_DATA_HI: if (w_rx_fire) w_next = S_DATA_LO;
      S_DATA_LO: if (w_rx_fire) w_next = S_WRITE;
      S_WRITE:   if (r_cnt == c_wr_last) w_next = S_IDLE;
      S_READ:    if (r_cnt == c_rd_last) w_next = S_TX_HI;
      S_TX_HI:   if (tx_ready) w_next = S_TX_LO;
      S_TX_LO:   if (tx_ready) w_next = S_IDLE;
      S_START:   w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  assign w_enter_write = (w_next == S_WRITE) && (r_state != S_WRITE);
  assign w_enter_read  = (w_next == S_READ)  && (r_state != S_READ);

  // ------------------------------------------------------------ datapath
  // Every output is registered from the next state, so it lines up with the
  // state it belongs to and nothing passes combinationally from an input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_write    <= 1'b0;
      r_is_data     <= 1'b0;
      r_addr        <= 16'h0000;
      r_wdata_hi    <= 8'h00;
      r_resp_lo     <= 8'h00;
      r_cnt         <= 8'h00;
      r_rx_ready    <= 1'b0;
      r_tx_data     <= 8'h00;
      r_tx_valid    <= 1'b0;
      r_addr_ext    <= 16'h0000;
      r_iram_in_ext <= 16'h0000;
      r_data_in_ext <= 16'h0000;
      r_wr_ins      <= 1'b0;
      r_wr_data     <= 1'b0;
      r_read_en     <= 2'b00;
      r_start       <= 1'b0;
      r_busy        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && w_rx_fire && w_op_legal) begin
        r_is_write <= w_op_write;
        r_is_data  <= w_op_data;
      end
      if (w_rx_fire && (r_state == S_ADDR_HI)) begin
        r_addr[15:8] <= rx_data;
      end
      if (w_rx_fire && ((r_state == S_ADDR_LO) || ((r_state == S_IDLE) && w_op_auto))) begin
        r_addr <= w_addr_word;
      end
      if (w_rx_fire && (r_state == S_DATA_HI)) begin
        r_wdata_hi <= rx_data;
      end

      if ((w_next == r_state) && ((r_state == S_WRITE) || (r_state == S_READ))) begin
        r_cnt <= r_cnt + 8'd1;
      end else begin
        r_cnt <= 8'h00;
      end

      if (w_enter_write || w_enter_read) begin
        r_addr_ext <= w_addr_word;
      end
      if (w_enter_write) begin
        if (r_is_data) begin
          r_data_in_ext <= {r_wdata_hi, rx_data};
        end else begin
          r_iram_in_ext <= {r_wdata_hi, rx_data};
        end
      end

      r_wr_ins  <= (w_next == S_WRITE) && !r_is_data;
      r_wr_data <= (w_next == S_WRITE) && r_is_data;
      r_read_en <= (w_next == S_READ) ? (w_sel_data ? 2'b10 : 2'b01) : 2'b00;

      // The high response byte goes straight from the memory word to tx_data
      // on the last READ cycle; only the low byte needs holding.
      if ((r_state == S_READ) && (w_next == S_TX_HI)) begin
        r_tx_data <= w_rd_word[15:8];
        r_resp_lo <= w_rd_word[7:0];
      end else if ((r_state == S_TX_HI) && (w_next == S_TX_LO)) begin
        r_tx_data <= r_resp_lo;
      end else if ((w_next != S_TX_HI) && (w_next != S_TX_LO)) begin
        r_tx_data <= 8'h00;
      end
      r_tx_valid <= (w_next == S_TX_HI) || (w_next == S_TX_LO);

      r_rx_ready <= (w_next == S_IDLE) || (w_next == S_ADDR_HI) || (w_next == S_ADDR_LO) ||
                    (w_next == S_DATA_HI) || (w_next == S_DATA_LO);
      r_busy     <= (w_next != S_IDLE);
      r_start    <= (w_next == S_START);
      r_err      <= (r_state == S_IDLE) && w_rx_fire && !w_op_legal && !w_op_go;
    end
  end

`ifdef LOADER_AUTOINC_EN
  // The pointer follows the address of the last completed access plus one;
  // a 16-bit add wraps 0xFFFF to 0x0000 on its own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 16'h0000;
    end else if (((r_state == S_WRITE) && (w_next == S_IDLE)) ||
                 ((r_state == S_READ) && (w_next == S_TX_HI))) begin
      r_ptr <= r_addr + 16'd1;
    end
  end
`endif

  assign rx_ready           = r_rx_ready;
  assign tx_data            = r_tx_data;
  assign tx_valid           = r_tx_valid;
  assign addr_ext           = r_addr_ext;
  assign iram_in_ext        = r_iram_in_ext;
  assign data_in_ext        = r_data_in_ext;
  assign mem_write_ins      = r_wr_ins;
  assign mem_write_data_ext = r_wr_data;
  assign read_en_ext        = r_read_en;
  assign start              = r_start;
  assign busy               = r_busy;
  assign err                = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_loader
// Purpose  : Self-checking bench for mem_loader. A table of commands with
//            hand-computed results, plus directed sequences for reset,
//            read latency, backpressure, GO, illegal opcodes, reset during a
//            write and (with LOADER_AUTOINC_EN) the address pointer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [15:0] addr_ext;
  logic [15:0] iram_in_ext;
  logic [15:0] data_in_ext;
  logic        mem_write_ins;
  logic        mem_write_data_ext;
  logic [1:0]  read_en_ext;
  logic [15:0] iram_in;
  logic [15:0] dram_in;
  logic        start;
  logic        busy;
  logic        err;

  mem_loader #(.READ_LAT(3), .WR_HOLD(2)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .rx_data            (rx_data),
    .rx_valid           (rx_valid),
    .rx_ready           (rx_ready),
    .tx_data            (tx_data),
    .tx_valid           (tx_valid),
    .tx_ready           (tx_ready),
    .addr_ext           (addr_ext),
    .iram_in_ext        (iram_in_ext),
    .data_in_ext        (data_in_ext),
    .mem_write_ins      (mem_write_ins),
    .mem_write_data_ext (mem_write_data_ext),
    .read_en_ext        (read_en_ext),
    .iram_in            (iram_in),
    .dram_in            (dram_in),
    .start              (start),
    .busy               (busy),
    .err                (err)
  );

  always #5 clk = ~clk;

  // ------------------------------------------------------- memory model
  // Address register plus output register: data appears two edges after
  // the address, matching a three-cycle read window.
  logic [15:0] mem_i [0:65535];
  logic [15:0] mem_d [0:65535];
  logic [15:0] i_stage, d_stage;
  logic        pre_we = 1'b0;
  logic        pre_sel = 1'b0;
  logic [15:0] pre_addr = 16'h0000;
  logic [15:0] pre_data = 16'h0000;

  always @(posedge clk) begin
    if (pre_we && !pre_sel) mem_i[pre_addr] <= pre_data;
    if (pre_we && pre_sel)  mem_d[pre_addr] <= pre_data;
    if (mem_write_ins)      mem_i[addr_ext] <= iram_in_ext;
    if (mem_write_data_ext) mem_d[addr_ext] <= data_in_ext;
    i_stage <= mem_i[addr_ext];
    d_stage <= mem_d[addr_ext];
    iram_in <= i_stage;
    dram_in <= d_stage;
  end

  // ------------------------------------------------------------ monitor
  int          n_wi, n_wd, n_err_pulse, n_start, n_conflict, tx_n;
  logic [15:0] wi_addr, wi_data, wd_addr, wd_data;
  logic [7:0]  tx_log [0:255];

  always @(negedge clk) begin
    if (mem_write_ins) begin
      n_wi <= n_wi + 1; wi_addr <= addr_ext; wi_data <= iram_in_ext;
    end
    if (mem_write_data_ext) begin
      n_wd <= n_wd + 1; wd_addr <= addr_ext; wd_data <= data_in_ext;
    end
    if (err)   n_err_pulse <= n_err_pulse + 1;
    if (start) n_start <= n_start + 1;
    if ((mem_write_ins && mem_write_data_ext) || (read_en_ext == 2'b11) ||
        ((mem_write_ins || mem_write_data_ext) && (read_en_ext != 2'b00)))
      n_conflict <= n_conflict + 1;
    if (tx_valid && tx_ready) begin
      tx_log[tx_n[7:0]] <= tx_data;
      tx_n <= tx_n + 1;
    end
  end

  // ------------------------------------------------------------ checking
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 60) begin
      @(posedge clk); #1; n++;
    end
    if (!rx_ready) begin
      n_vec++; n_bad++;
      $display("FAIL rx_timeout: rx_ready got 0 expected 1 for byte %h", b);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (busy) begin
      n_vec++; n_bad++;
      $display("FAIL idle_timeout: busy got 1 expected 0");
    end
    @(posedge clk); #1;
  endtask

  task automatic do_cmd(input logic [7:0] op, input logic [15:0] addr, input logic [15:0] data);
    logic [6:0] base;
    base = op[6:0];
    send_byte(op);
    if ((base >= 7'd1) && (base <= 7'd4) && (op[7] == 1'b0 || base != 7'd0)) begin
      if (!op[7]) begin
        send_byte(addr[15:8]);
        send_byte(addr[7:0]);
      end
      if (base <= 7'd2) begin
        send_byte(data[15:8]);
        send_byte(data[7:0]);
      end
    end
    wait_idle();
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [15:0] addr;
    logic [15:0] data;
    int          exp_wi;
    int          exp_wd;
    int          exp_ntx;
    logic [15:0] exp_rd;
    int          exp_err;
    int          exp_start;
  } vec_t;

  vec_t vecs [0:13];

  initial begin
    int s_wi, s_wd, s_err, s_start, s_tx, k, nbp;

    // op    addr      data      wi wd tx  rd        err start
    vecs[0]  = '{8'h01, 16'h0005, 16'h1234, 2, 0, 0, 16'h0000, 0, 0};
    vecs[1]  = '{8'h03, 16'h0005, 16'h0000, 0, 0, 2, 16'h1234, 0, 0};
    vecs[2]  = '{8'h02, 16'h0100, 16'hBEEF, 0, 2, 0, 16'h0000, 0, 0};
    vecs[3]  = '{8'h04, 16'h0100, 16'h0000, 0, 0, 2, 16'hBEEF, 0, 0};
    vecs[4]  = '{8'h03, 16'h0009, 16'h0000, 0, 0, 2, 16'hC0DE, 0, 0};
    vecs[5]  = '{8'h7F, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 1, 0};
    vecs[6]  = '{8'h05, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0, 1};
    vecs[7]  = '{8'h00, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 1, 0};
    vecs[8]  = '{8'hFF, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 1, 0};
    vecs[9]  = '{8'h02, 16'hFFFF, 16'h0001, 0, 2, 0, 16'h0000, 0, 0};
    vecs[10] = '{8'h04, 16'hFFFF, 16'h0000, 0, 0, 2, 16'h0001, 0, 0};
    vecs[11] = '{8'h01, 16'h0000, 16'hFFFF, 2, 0, 0, 16'h0000, 0, 0};
    vecs[12] = '{8'h03, 16'h0000, 16'h0000, 0, 0, 2, 16'hFFFF, 0, 0};
    vecs[13] = '{8'h06, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 1, 0};

    // Reset, with preloads of memory content the commands never write.
    #1 rst_n = 1'b0;
    #1;
    check("reset_outputs_zero", 32'(|{rx_ready, tx_valid, tx_data, addr_ext, iram_in_ext,
          data_in_ext, mem_write_ins, mem_write_data_ext, read_en_ext, start, busy, err}), 32'd0);
    pre_we = 1'b1; pre_sel = 1'b0; pre_addr = 16'h0009; pre_data = 16'hC0DE;
    @(posedge clk); #1;
    pre_sel = 1'b1; pre_addr = 16'h0003; pre_data = 16'hA55A;
    @(posedge clk); #1;
    pre_we = 1'b0;
    #1 rst_n = 1'b1;
    #1 check("rx_ready_low_before_edge", 32'(rx_ready), 32'd0);
    @(posedge clk); #1;
    check("rx_ready_after_release", 32'(rx_ready), 32'd1);

    // Table-driven commands.
    for (int i = 0; i < 14; i++) begin
      s_wi = n_wi; s_wd = n_wd; s_err = n_err_pulse; s_start = n_start; s_tx = tx_n;
      do_cmd(vecs[i].op, vecs[i].addr, vecs[i].data);
      check($sformatf("v%0d_wi_cycles", i), 32'(n_wi - s_wi), 32'(vecs[i].exp_wi));
      check($sformatf("v%0d_wd_cycles", i), 32'(n_wd - s_wd), 32'(vecs[i].exp_wd));
      check($sformatf("v%0d_err", i), 32'(n_err_pulse - s_err), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_start", i), 32'(n_start - s_start), 32'(vecs[i].exp_start));
      check($sformatf("v%0d_tx_count", i), 32'(tx_n - s_tx), 32'(vecs[i].exp_ntx));
      if (vecs[i].exp_wi > 0)
        check($sformatf("v%0d_wi_addr_data", i), {wi_addr, wi_data}, {vecs[i].addr, vecs[i].data});
      if (vecs[i].exp_wd > 0)
        check($sformatf("v%0d_wd_addr_data", i), {wd_addr, wd_data}, {vecs[i].addr, vecs[i].data});
      if (vecs[i].exp_ntx == 2)
        check($sformatf("v%0d_rd_word", i), {16'h0, tx_log[s_tx[7:0]], tx_log[8'(s_tx + 1)]},
              {16'h0, vecs[i].exp_rd});
    end

    // Read latency and backpressure: RDD 0x0003 (holds 0xA55A).
    tx_ready = 1'b0;
    send_byte(8'h04); send_byte(8'h00); send_byte(8'h03);
    check("rd_en_on_accept", 32'(read_en_ext), 32'd2);
    k = 0;
    while (!tx_valid && k < 20) begin
      @(posedge clk); #1; k++;
    end
    check("rd_latency_edges", 32'(k), 32'd3);
    nbp = 0;
    for (int i = 0; i < 10; i++) begin
      if (!(tx_valid && tx_data == 8'hA5 && read_en_ext == 2'b00)) nbp++;
      @(posedge clk); #1;
    end
    check("bp_hi_stable_cycles_bad", 32'(nbp), 32'd0);
    tx_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_lo_byte", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, 8'h5A});
    @(posedge clk); #1;
    check("bp_done", {30'h0, tx_valid, busy}, 32'd0);

    // GO: start for exactly one cycle, busy clear on the next.
    send_byte(8'h05);
    check("go_start_busy", {30'h0, start, busy}, 32'd3);
    @(posedge clk); #1;
    check("go_after", {30'h0, start, busy}, 32'd0);

    // Illegal opcode: err for one cycle, still accepting.
    send_byte(8'h7F);
    check("illegal_err_ready", {29'h0, err, rx_ready, busy}, 32'd6);
    @(posedge clk); #1;
    check("illegal_err_drop", 32'(err), 32'd0);

`ifndef LOADER_AUTOINC_EN
    s_err = n_err_pulse; s_wi = n_wi;
    send_byte(8'h81);
    @(posedge clk); #1;
    check("op81_illegal_err", 32'(n_err_pulse - s_err), 32'd1);
    check("op81_no_write", 32'(n_wi - s_wi + int'(busy)), 32'd0);
`endif

    // Reset during the first WRITE cycle of WRI 0x0009 <- 0xFFFF.
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h09); send_byte(8'hFF); send_byte(8'hFF);
    check("wr_strobe_on_accept", {15'h0, mem_write_ins, addr_ext}, {15'h0, 1'b1, 16'h0009});
    rst_n = 1'b0;
    #1;
    check("rst_mid_write_zero", 32'(|{rx_ready, tx_valid, tx_data, addr_ext, iram_in_ext,
          data_in_ext, mem_write_ins, mem_write_data_ext, read_en_ext, start, busy, err}), 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    s_tx = tx_n;
    do_cmd(8'h03, 16'h0009, 16'h0000);
    check("rd_after_reset", {16'h0, tx_log[s_tx[7:0]], tx_log[8'(s_tx + 1)]}, 32'h0000C0DE);

`ifdef LOADER_AUTOINC_EN
    do_cmd(8'h01, 16'h00FF, 16'h0001);
    do_cmd(8'h81, 16'h0000, 16'h0002);
    check("autoinc_addr", {wi_addr, wi_data}, 32'h01000002);
    do_cmd(8'h01, 16'hFFFE, 16'h1111);
    do_cmd(8'h81, 16'h0000, 16'h2222);
    check("autoinc_ffff", {wi_addr, wi_data}, 32'hFFFF2222);
    do_cmd(8'h81, 16'h0000, 16'h3333);
    check("autoinc_wrap", {wi_addr, wi_data}, 32'h00003333);
`endif

    check("no_enable_conflicts", 32'(n_conflict), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
